// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter: accepts a WIDTH-bit word over valid/ready and shifts it out one bit per clock.
// Optional feature macro: PISO_TX_PARITY_EN appends an even-parity bit after the data bits.
module piso_shift_tx #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

`ifdef PISO_TX_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } state_t;
`endif

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ser_out_d, ser_valid_d, ser_last_d, done_d;
    logic               last_bit;
`ifdef PISO_TX_PARITY_EN
    logic               par_q, par_d;
`endif

    assign load_ready = (state_q == IDLE);
    assign busy       = ~load_ready;
    assign last_bit   = (cnt_q == CNT_W'(WIDTH - 1));

    // Next-state and next-output logic; outputs are registered one cycle ahead of display.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        ser_out_d   = 1'b0;
        ser_valid_d = 1'b0;
        ser_last_d  = 1'b0;
        done_d      = 1'b0;
`ifdef PISO_TX_PARITY_EN
        par_d       = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    state_d     = SHIFT;
                    shreg_d     = data_in;
                    cnt_d       = '0;
                    ser_valid_d = 1'b1;
                    ser_out_d   = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
`ifdef PISO_TX_PARITY_EN
                    par_d       = ^data_in;
`endif
                end
            end
            SHIFT: begin
                cnt_d   = cnt_q + CNT_W'(1);
                shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                    : {1'b0, shreg_q[WIDTH-1:1]};
                if (last_bit) begin
`ifdef PISO_TX_PARITY_EN
                    state_d     = PARITY;
                    ser_valid_d = 1'b1;
                    ser_out_d   = par_q;
                    ser_last_d  = 1'b1;
`else
                    state_d     = IDLE;
                    done_d      = 1'b1;
`endif
                end else begin
                    ser_valid_d = 1'b1;
                    ser_out_d   = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
`ifdef PISO_TX_PARITY_EN
                    ser_last_d  = 1'b0;
`else
                    ser_last_d  = (cnt_q == CNT_W'(WIDTH - 2));
`endif
                end
            end
`ifdef PISO_TX_PARITY_EN
            PARITY: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
            done      <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            ser_out   <= ser_out_d;
            ser_valid <= ser_valid_d;
            ser_last  <= ser_last_d;
            done      <= done_d;
`ifdef PISO_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed bench for piso_shift_tx: MSB-first and LSB-first instances share the same stimulus.
module tb_piso_shift_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_valid;
    logic [7:0] data_in;
    logic       load_ready, ser_out, ser_valid, ser_last, busy, done;
    logic       l_load_ready, l_ser_out, l_ser_valid, l_ser_last, l_busy, l_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .data_in(data_in), .ser_out(ser_out), .ser_valid(ser_valid),
        .ser_last(ser_last), .busy(busy), .done(done)
    );

    piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(l_load_ready),
        .data_in(data_in), .ser_out(l_ser_out), .ser_valid(l_ser_valid),
        .ser_last(l_ser_last), .busy(l_busy), .done(l_done)
    );

    typedef struct {
        logic [7:0] word;
        logic [7:0] s_msb;   // stream order, bit 7 sent first
        logic [7:0] s_lsb;
        logic       par;
        int         gap;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%b exp=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, ser_valid, 1'b0);
        chk({tag, "_out"}, ser_out, 1'b0);
        chk({tag, "_last"}, ser_last, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_ready"}, load_ready, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_lvalid"}, l_ser_valid, 1'b0);
    endtask

    // Sends one frame; returns at the negedge of the done cycle.
    task automatic run_frame(input logic [7:0] w, input logic [7:0] s_msb,
                             input logic [7:0] s_lsb, input logic par, input logic keep_busy);
        logic exp_last;
        chk("ready_pre", load_ready, 1'b1);
        load_valid = 1'b1;
        data_in    = w;
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) begin
                if (keep_busy) data_in = 8'hFF;
                else load_valid = 1'b0;
            end
`ifdef PISO_TX_PARITY_EN
            exp_last = 1'b0;
`else
            exp_last = (i == 7);
`endif
            chk("msb_bit", ser_out, s_msb[7-i]);
            chk("lsb_bit", l_ser_out, s_lsb[7-i]);
            chk("valid", ser_valid, 1'b1);
            chk("lvalid", l_ser_valid, 1'b1);
            chk("last", ser_last, exp_last);
            chk("llast", l_ser_last, exp_last);
            chk("ready_busy", load_ready, 1'b0);
            chk("busy", busy, 1'b1);
            chk("done_early", done, 1'b0);
        end
`ifdef PISO_TX_PARITY_EN
        @(negedge clk);
        chk("par_valid", ser_valid, 1'b1);
        chk("par_bit", ser_out, par);
        chk("lpar_bit", l_ser_out, par);
        chk("par_last", ser_last, 1'b1);
        chk("par_done", done, 1'b0);
        chk("par_busy", busy, 1'b1);
`else
        chk("par_unused", par, par ^ 1'b0 ^ (w[0] & 1'b0));
        checks--;
`endif
        @(negedge clk);
        chk("done", done, 1'b1);
        chk("ldone", l_done, 1'b1);
        chk("done_valid", ser_valid, 1'b0);
        chk("done_out", ser_out, 1'b0);
        chk("done_last", ser_last, 1'b0);
        chk("done_ready", load_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{word: 8'hA5, s_msb: 8'hA5, s_lsb: 8'hA5, par: 1'b0, gap: 1};
        vecs[1] = '{word: 8'h01, s_msb: 8'h01, s_lsb: 8'h80, par: 1'b1, gap: 0};
        vecs[2] = '{word: 8'h07, s_msb: 8'h07, s_lsb: 8'hE0, par: 1'b1, gap: 2};
        vecs[3] = '{word: 8'h03, s_msb: 8'h03, s_lsb: 8'hC0, par: 1'b0, gap: 0};
        vecs[4] = '{word: 8'hB6, s_msb: 8'hB6, s_lsb: 8'h6D, par: 1'b1, gap: 1};
        vecs[5] = '{word: 8'h4E, s_msb: 8'h4E, s_lsb: 8'h72, par: 1'b0, gap: 0};

        // Reset held two cycles with a word offered
        rst        = 1'b1;
        load_valid = 1'b1;
        data_in    = 8'hA5;
        @(negedge clk);
        chk_idle("rst1");
        @(negedge clk);
        chk_idle("rst2");
        rst        = 1'b0;
        load_valid = 1'b0;
        @(negedge clk);
        chk_idle("post_rst");

        // Table-driven frames, some with idle gaps, others back-to-back
        foreach (vecs[v]) begin
            run_frame(vecs[v].word, vecs[v].s_msb, vecs[v].s_lsb, vecs[v].par, 1'b0);
            for (int g = 0; g < vecs[v].gap; g++) begin
                @(negedge clk);
                chk_idle("gap");
            end
        end

        // Busy ignore: 8'hFF offered throughout the 8'h3C frame, then accepted on the done edge
        run_frame(8'h3C, 8'h3C, 8'h3C, 1'b0, 1'b1);
        run_frame(8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
        @(negedge clk);
        chk_idle("after_b2b");

        // Mid-frame reset after three bits of 8'hA5
        load_valid = 1'b1;
        data_in    = 8'hA5;
        @(posedge clk);
        @(negedge clk);
        load_valid = 1'b0;
        chk("mid_b0", ser_out, 1'b1);
        @(negedge clk);
        chk("mid_b1", ser_out, 1'b0);
        @(negedge clk);
        chk("mid_b2", ser_out, 1'b1);
        chk("mid_busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle("mid_rst");
        for (int g = 0; g < 10; g++) begin
            @(negedge clk);
            chk("mid_no_done", done, 1'b0);
            chk("mid_no_valid", ser_valid, 1'b0);
        end
        run_frame(8'h81, 8'h81, 8'h81, 1'b0, 1'b0);
        @(negedge clk);
        chk_idle("end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_shift_tx.md
Name: piso_shift_tx

Overview:
- Parallel-in/serial-out transmitter: captures a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock with a valid strobe.
- It is the send end of the team's serial capture path; a SIPO/latch-based receiver reassembles the word at the far end.
- It provides the bit stream used to exercise the storage elements (latches, flops) in the same library.

Parameters:
- WIDTH, 8, number of data bits per frame (legal range 2 to 32).
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- load_valid  input  1  data_in holds a word to send.
- load_ready  output  1  block can accept a word; combinational, equals (state == IDLE).
- data_in  input  WIDTH  parallel word; sampled only on the accept edge.
- ser_out  output  1  serial data bit (registered).
- ser_valid  output  1  ser_out carries a frame bit this cycle (registered).
- ser_last  output  1  high with the final bit of the frame (registered).
- busy  output  1  frame in progress; equals ~load_ready.
- done  output  1  one-cycle pulse after the frame's final bit (registered).

Behaviour:
- Reset (rst=1 at an edge):
  - state = IDLE; shift register = 0; bit counter = 0.
  - ser_out = 0, ser_valid = 0, ser_last = 0, done = 0.
  - load_ready = 1 from the cycle after reset.
- Reset has priority over every other event and aborts a frame in progress. No done pulse is produced and no further bits are sent.
- Accept: the edge where load_valid & load_ready = 1 (call it edge k).
  - data_in is copied into the shift register and the counter is cleared.
  - state goes to SHIFT.
- In IDLE, load_valid = 0 leaves all state unchanged.
- SHIFT:
  - In cycles k+1 through k+WIDTH: ser_valid = 1 and ser_out = the current bit, in the order set by MSB_FIRST.
  - The counter increments every cycle.
  - ser_last = 1 only in cycle k+WIDTH (without PARITY_EN).
- Exit from SHIFT: after the last bit, state returns to IDLE. In cycle k+WIDTH+1:
  - done = 1, ser_valid = 0, ser_out = 0, load_ready = 1.
- Back-to-back: a word presented with load_valid = 1 during the done cycle is accepted at that edge. This gives exactly one idle cycle between frames.
- Busy handling: load_valid while busy is ignored. The word is not latched and data_in changes have no effect on the frame in progress.
- Idle line level: ser_out = 0 whenever ser_valid = 0.
- Counter width: clog2(WIDTH+1) bits. It never wraps within a frame and is cleared on accept.
- States: IDLE, SHIFT, plus PARITY when PARITY_EN is defined.

Optional Feature:
- Macro: PIASO_PARITY_EN is not used; the macro is PISO_TX_PARITY_EN.
- Defined:
  - After the WIDTH data bits, state goes to PARITY for one cycle (k+WIDTH+1).
  - In that cycle: ser_valid = 1, ser_out = XOR of the captured word (even parity), ser_last = 1.
  - ser_last is 0 on the final data bit.
  - done pulses at k+WIDTH+2.
- Undefined: the PARITY state and its logic are absent. Timing is exactly as described under Behaviour.

Test Plan:
- Reset: hold rst = 1 for 2 cycles with load_valid = 1 -> ser_out = 0, ser_valid = 0, ser_last = 0, done = 0, load_ready = 1 after release; nothing accepted while rst is high.
- MSB-first send (WIDTH = 8): accept 8'hA5 at edge k -> ser_out = 1,0,1,0,0,1,0,1 in cycles k+1..k+8 with ser_valid = 1; ser_last = 1 only at k+8; done = 1 at k+9.
- LSB-first (MSB_FIRST = 0): accept 8'h01 -> first bit 1, then seven 0s; done at k+9.
- Busy ignore and back-to-back:
  - Accept 8'h3C, then drive 8'hFF with load_valid = 1 during the shift -> load_ready = 0 and stream = 0,0,1,1,1,1,0,0.
  - Keep load_valid = 1 with 8'hFF -> accepted on the done edge; its first bit appears 1 cycle after done.
- Mid-frame reset: assert rst after 3 bits of 8'hA5 -> next cycle ser_valid = 0, load_ready = 1, no done pulse; the following frame with 8'h81 transmits correctly.
- With PISO_TX_PARITY_EN defined: send 8'h07 -> 8 data bits, then parity bit 1 at k+9 with ser_last = 1, done at k+10; send 8'h03 -> parity bit 0.
